// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding and controller states.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// Shift-add multiplier for seq_alu; built only when SEQ_ALU_MUL_EN is defined.
// Bit 0 is folded in at start, so `product` is final while `done` is high.
`ifdef SEQ_ALU_MUL_EN
module seq_alu_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] partial;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      cnt_reg;

    // The pending partial product is added combinationally so the caller can
    // latch the full product on the same edge as the last step.
    assign partial = mplier_reg[0] ? mcand_reg : '0;
    assign product = acc_reg + partial;
    assign done    = (cnt_reg == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
        end else if (start) begin
            acc_reg    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand_reg  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier_reg <= b >> 1;
            cnt_reg    <= CW'(WIDTH - 1);
        end else if (step && cnt_reg != '0) begin
            acc_reg    <= product;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg - CW'(1);
        end
    end

endmodule
`endif

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes and Z/C/V/ERR flags.
// Define SEQ_ALU_MUL_EN to build the multi-cycle multiplier; otherwise MUL reports flag_err.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_err
);

    localparam int MSB = WIDTH - 1;

    state_e             state_reg;
    logic               init_done_reg;
    logic               out_valid_reg;
    logic [WIDTH-1:0]   out_reg;
    logic               z_reg;
    logic               c_reg;
    logic               v_reg;
    logic               err_reg;

    opcode_e            op;
    logic               accept;
    logic               go_busy;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic               shift_oob;
    logic [WIDTH-1:0]   res_next;
    logic               c_next;
    logic               v_next;
    logic               err_next;

    assign op        = opcode_e'(opcode);
    // init_done_reg keeps in_ready low until the first edge after reset release.
    assign in_ready  = en && init_done_reg && (state_reg == ST_IDLE);
    assign accept    = in_valid && in_ready;

    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign flag_z    = z_reg;
    assign flag_c    = c_reg;
    assign flag_v    = v_reg;
    assign flag_err  = err_reg;

    assign sum_ext   = {1'b0, in_1} + {1'b0, in_2};
    assign diff_ext  = {1'b0, in_1} - {1'b0, in_2};
    assign shift_oob = 32'(in_2) >= 32'(WIDTH);

`ifdef SEQ_ALU_MUL_EN
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    assign mul_start = accept && (op == OP_MUL);
    assign go_busy   = (op == OP_MUL);

    seq_alu_mul #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .step    (en),
        .a       (in_1),
        .b       (in_2),
        .product (mul_product),
        .done    (mul_done)
    );
`else
    assign go_busy = 1'b0;
`endif

    always_comb begin
        res_next = '0;
        c_next   = 1'b0;
        v_next   = 1'b0;
        err_next = 1'b0;
        case (op)
            OP_ADD: begin
                res_next = sum_ext[MSB:0];
                c_next   = sum_ext[WIDTH];
                v_next   = (in_1[MSB] == in_2[MSB]) && (sum_ext[MSB] != in_1[MSB]);
            end
            OP_SUB: begin
                res_next = diff_ext[MSB:0];
                c_next   = diff_ext[WIDTH];
                v_next   = (in_1[MSB] != in_2[MSB]) && (diff_ext[MSB] != in_1[MSB]);
            end
            OP_AND:  res_next = in_1 & in_2;
            OP_OR:   res_next = in_1 | in_2;
            OP_XOR:  res_next = in_1 ^ in_2;
            OP_SHL:  res_next = shift_oob ? '0 : (in_1 << in_2);
            OP_SHR:  res_next = shift_oob ? '0 : (in_1 >> in_2);
`ifndef SEQ_ALU_MUL_EN
            OP_MUL:  err_next = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            init_done_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            z_reg         <= 1'b0;
            c_reg         <= 1'b0;
            v_reg         <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            init_done_reg <= 1'b1;
            if (en) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (accept) begin
                            if (go_busy) begin
                                state_reg <= ST_BUSY;
                            end else begin
                                state_reg     <= ST_DONE;
                                out_valid_reg <= 1'b1;
                                out_reg       <= res_next;
                                z_reg         <= (res_next == '0);
                                c_reg         <= c_next;
                                v_reg         <= v_next;
                                err_reg       <= err_next;
                            end
                        end
                    end
`ifdef SEQ_ALU_MUL_EN
                    ST_BUSY: begin
                        if (mul_done) begin
                            state_reg     <= ST_DONE;
                            out_valid_reg <= 1'b1;
                            out_reg       <= mul_product[MSB:0];
                            z_reg         <= (mul_product[MSB:0] == '0);
                            c_reg         <= |mul_product[2*WIDTH-1:WIDTH];
                            v_reg         <= 1'b0;
                            err_reg       <= 1'b0;
                        end
                    end
`endif
                    ST_DONE: begin
                        if (out_ready) begin
                            state_reg     <= ST_IDLE;
                            out_valid_reg <= 1'b0;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=4) against an integer-arithmetic reference model.
// Expectations follow SEQ_ALU_MUL_EN when the bench is built with it.
module tb_seq_alu;

    localparam int W = 4;
`ifdef SEQ_ALU_MUL_EN
    localparam int MUL_LAT = W;
    localparam int STALL_LAT = W + 2;
    localparam logic STALL_OV3 = 1'b0;
`else
    localparam int MUL_LAT = 1;
    localparam int STALL_LAT = 1;
    localparam logic STALL_OV3 = 1'b1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   opcode;
    logic [W-1:0] in_1;
    logic [W-1:0] in_2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         flag_z;
    logic         flag_c;
    logic         flag_v;
    logic         flag_err;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .in_1      (in_1),
        .in_2      (in_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_err  (flag_err)
    );

    always #5 clk = ~clk;

    // Reference: {result, Z, C, V, ERR} from plain integer arithmetic.
    function automatic logic [W+3:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int ia, ib, sa, sb, s, r, mask;
        bit c, v, e;
        ia = int'(a); ib = int'(b);
        mask = (1 << W) - 1;
        sa = (ia >= (1 << (W-1))) ? ia - (1 << W) : ia;
        sb = (ib >= (1 << (W-1))) ? ib - (1 << W) : ib;
        c = 0; v = 0; e = 0; r = 0;
        case (op)
            3'd0: begin r = ia + ib; c = (r > mask); s = sa + sb; v = (s > mask/2) || (s < -(mask/2) - 1); end
            3'd1: begin r = ia - ib; c = (ia < ib); s = sa - sb; v = (s > mask/2) || (s < -(mask/2) - 1); end
            3'd2: r = ia & ib;
            3'd3: r = ia | ib;
            3'd4: r = ia ^ ib;
            3'd5: r = (ib >= W) ? 0 : ia * (1 << ib);
            3'd6: r = (ib >= W) ? 0 : ia / (1 << ib);
            default: begin
`ifdef SEQ_ALU_MUL_EN
                r = ia * ib; c = (r > mask);
`else
                r = 0; e = 1;
`endif
            end
        endcase
        r = r & mask;
        return {W'(r), (r == 0), c, v, e};
    endfunction

    function automatic logic [W+3:0] observed();
        return {out, flag_z, flag_c, flag_v, flag_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation and returns cycles until out_valid (-1 on timeout).
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
        if (in_ready !== 1'b1) begin lat = -1; return; end
        in_valid = 1'b1; opcode = op; in_1 = a; in_2 = b;
        tick();
        in_valid = 1'b0; opcode = 3'($urandom); in_1 = W'($urandom); in_2 = W'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 50) begin tick(); lat++; end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; in_1 = '0; in_2 = '0;
        tick(); tick();
        checks++;
        if ({in_ready, out_valid, observed()} !== '0)
            $display("FAIL reset_state: got %h expected 0", {in_ready, out_valid, observed()});
        if ({in_ready, out_valid, observed()} !== '0) errors++;
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [2:0]   ops [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd7, 3'd6};
        logic [W-1:0] as  [6] = '{4'h9, 4'h3, 4'hA, 4'h3, 4'h7, 4'hC};
        logic [W-1:0] bs  [6] = '{4'h8, 4'h5, 4'hA, 4'h5, 4'h3, 4'h2};
        logic [W+3:0] exp, got, mul_exp;
        int lat, exp_lat;
`ifdef SEQ_ALU_MUL_EN
        mul_exp = {4'h5, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        mul_exp = {4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], lat);
            exp_lat = (ops[i] == 3'd7) ? MUL_LAT : 1;
            exp = model(ops[i], as[i], bs[i]);
            got = observed();
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL dir_latency op=%0d: got %0d expected %0d", ops[i], lat, exp_lat);
            end
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL dir_result op=%0d a=%h b=%h: got %h expected %h", ops[i], as[i], bs[i], got, exp);
            end
            if (i == 0) begin
                checks++;
                if (got !== {4'h1, 1'b0, 1'b1, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL add_9_8: got %h expected 16", got);
                end
            end
            if (i == 4) begin
                checks++;
                if (got !== mul_exp) begin
                    errors++;
                    $display("FAIL mul_7_3: got %h expected %h", got, mul_exp);
                end
            end
            drain();
        end
    endtask

    task automatic test_random();
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic [W+3:0] exp;
        int lat, exp_lat, hold;
        bit early;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom); a = W'($urandom); b = W'($urandom);
            early = ($urandom_range(0, 3) == 0);
            out_ready = early;
            issue(op, a, b, lat);
            exp_lat = (op == 3'd7) ? MUL_LAT : 1;
            exp = model(op, a, b);
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL rnd_latency op=%0d: got %0d expected %0d", op, lat, exp_lat);
            end
            checks++;
            if (observed() !== exp) begin
                errors++;
                $display("FAIL rnd_result op=%0d a=%h b=%h: got %h expected %h", op, a, b, observed(), exp);
            end
            if (early) begin
                tick();
                out_ready = 1'b0;
            end else begin
                hold = $urandom_range(0, 2);
                for (int h = 0; h < hold; h++) begin
                    tick();
                    checks++;
                    if (out_valid !== 1'b1 || observed() !== exp) begin
                        errors++;
                        $display("FAIL rnd_hold: got valid=%b %h expected 1 %h", out_valid, observed(), exp);
                    end
                end
                drain();
            end
            checks++;
            if (out_valid !== 1'b0 || observed() !== exp) begin
                errors++;
                $display("FAIL rnd_drain: got valid=%b %h expected 0 %h", out_valid, observed(), exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W+3:0] exp;
        int lat;
        exp = model(3'd0, 4'h5, 4'h6);
        issue(3'd0, 4'h5, 4'h6, lat);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; opcode = 3'd4; in_1 = 4'h3; in_2 = 4'h9;
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== exp) begin
                errors++;
                $display("FAIL bp_hold: got valid=%b ready=%b %h expected 1 0 %h", out_valid, in_ready, observed(), exp);
            end
        end
        in_valid = 1'b0;
        drain();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || observed() !== exp) begin
            errors++;
            $display("FAIL bp_not_queued: got valid=%b %h expected 0 %h", out_valid, observed(), exp);
        end
    endtask

    task automatic test_en_stall();
        logic [W+3:0] exp, got;
        int lat;
        logic ov3;
        exp = model(3'd7, 4'h7, 4'h3);
        got = '0; ov3 = 1'bx; lat = -1;
        in_valid = 1'b1; opcode = 3'd7; in_1 = 4'h7; in_2 = 4'h3; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_1 = W'($urandom); in_2 = W'($urandom);
        for (int k = 1; k <= 12; k++) begin
            if (out_valid === 1'b1 && lat < 0) begin lat = k; got = observed(); end
            if (k == 3) ov3 = out_valid;
            en = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            tick();
        end
        en = 1'b1; out_ready = 1'b0;
        checks++;
        if (lat != STALL_LAT) begin
            errors++;
            $display("FAIL stall_latency: got %0d expected %0d", lat, STALL_LAT);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL stall_result: got %h expected %h", got, exp);
        end
        checks++;
        if (ov3 !== STALL_OV3) begin
            errors++;
            $display("FAIL stall_valid_hold: got %b expected %b", ov3, STALL_OV3);
        end
        en = 1'b0; in_valid = 1'b1; opcode = 3'd0; in_1 = 4'h1; in_2 = 4'h1;
        tick(); tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || observed() !== exp) begin
            errors++;
            $display("FAIL en_low_idle: got ready=%b valid=%b %h expected 0 0 %h", in_ready, out_valid, observed(), exp);
        end
        in_valid = 1'b0; en = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        issue(3'd0, 4'h1, 4'h1, lat);
        drain();
        in_valid = 1'b1; opcode = 3'd7; in_1 = 4'h7; in_2 = 4'h3;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, observed()} !== '0) begin
            errors++;
            $display("FAIL reset_mid_mul: got %h expected 0", {in_ready, out_valid, observed()});
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_stale: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic [W+3:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            op = 3'($urandom_range(0, 6)); a = W'($urandom); b = W'($urandom);
            exp = model(op, a, b);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready: got %b expected 1", in_ready);
            end
            in_valid = 1'b1; opcode = op; in_1 = a; in_2 = b;
            tick();
            opcode = 3'($urandom_range(0, 6)); in_1 = W'($urandom); in_2 = W'($urandom);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== exp) begin
                errors++;
                $display("FAIL b2b_result op=%0d: got valid=%b ready=%b %h expected 1 0 %h", op, out_valid, in_ready, observed(), exp);
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_en_stall();
        test_reset_mid_mul();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU with valid/ready handshakes and status flags; the next generation of the combinational 4-bit ALU in the Tiny Tapeout top. Operands and opcode are accepted on an input handshake, and the result plus flags are held on an output handshake until consumed. Multiply is multi-cycle (shift-add). The block sits between the top-level pin mux and `uo_out`/`uio_out`.

## Interface
- `WIDTH`, default 4: operand/result width, ≥2.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: enable (driven from `ena`); low freezes all state.
- `in_valid` in 1: operands/opcode valid.
- `in_ready` out 1: block can accept.
- `opcode` in 3: operation select.
- `in_1` in WIDTH: operand A.
- `in_2` in WIDTH: operand B.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer takes result.
- `out` out WIDTH: result.
- `flag_z` out 1: result == 0.
- `flag_c` out 1: carry/borrow/high-product.
- `flag_v` out 1: signed overflow.
- `flag_err` out 1: unsupported op.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
- FSM states:
  - IDLE: `in_ready`=`en`.
  - BUSY: MUL in progress, `in_ready`=0.
  - DONE: `out_valid`=1, `in_ready`=0.
- Transitions:
  - Accept (`in_valid`&`in_ready`): non-MUL op → DONE; MUL → BUSY.
  - BUSY → DONE after WIDTH step cycles.
  - DONE & `out_ready` → IDLE.
- Operands and opcode are captured at accept; later input changes have no effect.
- Arithmetic rules (all modulo 2^WIDTH, unsigned unless stated):
  - ADD: `flag_c` = carry out; `flag_v` = two's-complement overflow.
  - SUB: `in_1`−`in_2`; `flag_c` = borrow (`in_1`<`in_2`); `flag_v` = signed overflow.
  - Logic ops: `flag_c`=`flag_v`=0.
  - SHL/SHR: shift by unsigned `in_2`; if `in_2`≥WIDTH, result 0. `flag_c`=`flag_v`=0.
  - MUL: `out` = low WIDTH bits of the product; `flag_c` = 1 if the high WIDTH bits are nonzero; `flag_v`=0.
- `flag_z` = (`out`==0) for every op.
- `flag_err`=0 except as defined under Configuration.
- `out` and all flags are registered. They are stable while `out_valid`=1 and are not cleared after the handshake; they hold their last value.
- `en` low: no state, counter or register changes; `in_ready`=0; `out_valid` holds its value. A handshake on `out` completes only when `en`=1.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE; `in_ready`=0 while in reset; `out_valid`=0; `out`=0; all flags=0; step counter=0.
- Reset asserted mid-MUL aborts the operation with no output.
- Latency, with accept at edge N:
  - Non-MUL: `out_valid`=1 after edge N+1.
  - MUL: `out_valid`=1 after edge N+WIDTH, plus one cycle per cycle `en` is low.
- Throughput: one operation per 2 cycles for non-MUL ops (accept, then drain). There is no overlap of output and input handshakes.
- `out_ready` may be asserted before `out_valid`; the handshake completes on the first edge where both are 1.
- `in_valid` asserted while `in_ready`=0 is ignored and not queued.

## Configuration
- `SEQ_ALU_MUL_EN` defined: MUL implemented as above; instantiates the multiplier sub-module.
- `SEQ_ALU_MUL_EN` undefined: no multiplier logic and BUSY is unreachable. MUL completes like a 1-cycle op with `out`=0, `flag_z`=1, `flag_c`=`flag_v`=0, `flag_err`=1.

## Structure
- Shared package `seq_alu_pkg`:
  - opcode enum (`OP_ADD`…`OP_MUL`, 3 bits);
  - FSM state enum (`ST_IDLE`, `ST_BUSY`, `ST_DONE`).
- Sub-module `seq_alu_mul`: WIDTH-parametrised shift-add multiplier.
  - Inputs: `start`, `step` (= `en`).
  - Outputs: 2·WIDTH product, `done`.
  - Present only under `SEQ_ALU_MUL_EN`.

## Test plan (WIDTH=4)
- ADD 0x9+0x8 → `out`=0x1, C=1, V=1, Z=0; `out_valid` one cycle after accept.
- SUB 0x3−0x5 → `out`=0xE, C=1, V=0. Then XOR 0xA^0xA → `out`=0, Z=1. SHL 0x3 by 5 → `out`=0.
- MUL 0x7×0x3 → `out`=0x5, C=1; `out_valid` 4 cycles after accept. Without macro: `out`=0, `flag_err`=1, latency 1.
- Backpressure: `out_ready`=0 for 3 cycles after result → `out`/flags stable, `in_ready`=0, a new `in_valid` is ignored; `out_ready`=1 → IDLE next cycle.
- `en`=0 for 2 cycles during MUL BUSY → result unchanged (0x7×0x3 → 0x5), latency 6.
- `rst_n` pulsed low mid-MUL → all outputs 0 immediately. After release, `in_ready`=1 next cycle and no stale `out_valid`.
